led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Avalon-MM slave that time-multiplexes an 8x8 LED matrix.
- Sits directly downstream of the CPU's LED PIOs. It replaces software row-bit-banging through leds_rows with hardware scanning.
- Software writes column patterns into a back buffer, then requests a swap. The block drives one-hot row selects and column data at a prescaled row rate, with inter-row blanking.

Parameters:
- PRESCALE, 50000: clock cycles per row period. Must be >= 2.
- BLANK, 2: cycles at the start of each row period with rows and columns off. Must satisfy 0 <= BLANK < PRESCALE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  4  register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational, zero-extended
- row_sel  out  8  one-hot active row, registered
- col_data  out  8  column pattern for the active row, registered
- frame_tick  out  1  one-cycle pulse at frame wrap, registered

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on reset.
- Reset values:
  - All back/front rows 0.
  - ctrl 0, swap_pending 0, row_idx 0, prescale count 0, frame_count 0.
  - row_sel 0, col_data 0, frame_tick 0.
- Register map (write = chipselect & ~write_n):
  - 0-7: back[addr] R/W. Writes take writedata[7:0].
  - 8: CTRL R/W.
    - bit0 enable.
    - bit1 invert (active-low columns).
    - bit2 swap request: write-1 sets swap_pending; reads as 0; writing 0 has no effect.
  - 9: STATUS RO = {16'b0, frame_count[7:0] at [15:8], 3'b0, swap_pending at [4], 1'b0, row_idx[2:0]}.
  - 10-15: read 0, writes ignored.
- Scan engine, while enable=1:
  - cnt counts 0..PRESCALE-1.
  - At cnt=PRESCALE-1: cnt->0 and row_idx increments, wrapping 7->0.
  - On the 7->0 wrap:
    - frame_count increments, wrapping 255->0.
    - frame_tick pulses for one cycle.
    - If swap_pending: front[0..7] <= back[0..7] and swap_pending clears.
- Outputs, registered: they reflect the cycle's engine state one clock later.
  - Visible (enable & cnt >= BLANK): row_sel = 1<<row_idx; col_data = front[row_idx] ^ {8{invert}}.
  - Otherwise: row_sel = 0; col_data = {8{invert}}, i.e. LEDs off.
- Enable:
  - A write setting enable takes effect the next cycle. The first period starts with row_idx=0, cnt=0.
  - Clearing enable mid-scan: next cycle cnt=0 and row_idx=0; outputs blank the following cycle. frame_count and buffers are kept.
- Swap with enable=0: takes effect on the cycle after swap_pending is set. No frame_tick.
- Simultaneous events:
  - A back write in the same cycle as a swap: the front gets the pre-write back value; back gets the new value.
  - A swap request in the same cycle as a wrap: swap_pending is set and is applied at the next wrap.
  - A CTRL write that both sets swap and clears enable: the swap applies the following cycle.
- Reset mid-scan: synchronous reset wins over every other event that cycle. Outputs are 0 the cycle after.
- readdata is valid combinationally whenever address is stable; chipselect is not required for reads.

Test Plan:
1. Reset and readback:
   - Stimulus: assert reset 2 cycles, release. Read addr 0-9.
   - Required: every read returns 0; row_sel=0, col_data=0.
   - Stimulus: write back[3]=0x1A5, then read.
   - Required: reads 0x000000A5.
2. Scan timing (PRESCALE=4, BLANK=1):
   - Stimulus: load rows 0x01..0x80, request swap, enable.
   - Required: row_sel sequence per period is 00,01,01,01 then 00,02,02,02 … 00,80,80,80; col_data tracks row_sel. frame_tick pulses once per 32 cycles; STATUS[15:8] increments.
3. Double buffering:
   - Stimulus: while scanning, write back[0]=0xFF without swap.
   - Required: col_data for row 0 is unchanged.
   - Stimulus: request swap.
   - Required: STATUS[4]=1 until the next wrap. The first row-0 visible cycle after the wrap shows 0xFF and STATUS[4]=0.
4. Invert:
   - Stimulus: CTRL=0x3 with front[2]=0x0F.
   - Required: blank cycles drive col_data=0xFF; row 2 visible drives 0xF0.
5. Disable mid-scan:
   - Stimulus: clear enable while row_idx=5.
   - Required: STATUS[2:0]=0 next cycle; row_sel=0 within 2 cycles. Re-enable restarts at row 0.
6. Collisions:
   - Stimulus: write back[0]=0x55 in the exact wrap cycle with swap pending (old back[0]=0xAA).
   - Required: front[0]=0xAA after the swap; back[0] reads 0x55.
   - Stimulus: assert reset mid-frame.
   - Required: all outputs and STATUS are 0 after one cycle.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Avalon-MM slave that scans an 8x8 LED matrix from a double-buffered frame store.
// Software fills the back buffer and requests a swap, which lands on the next frame wrap.
module led_matrix_scanner #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_tick
);

    localparam int                CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]        ADDR_CTRL   = 4'd8;
    localparam logic [3:0]        ADDR_STATUS = 4'd9;

    logic [7:0]       back_q  [8];
    logic [7:0]       back_d  [8];
    logic [7:0]       front_q [8];
    logic [7:0]       front_d [8];
    logic             enable_q, enable_d;
    logic             invert_q, invert_d;
    logic             swap_pending_q, swap_pending_d;
    logic [2:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic [7:0]       row_sel_q, row_sel_d;
    logic [7:0]       col_data_q, col_data_d;
    logic             frame_tick_q, frame_tick_d;

    logic wr_en, back_wr, ctrl_wr;
    logic row_done, frame_wrap, swap_apply;
    logic blank_done, visible;
    logic unused_writedata;

    assign wr_en   = chipselect & ~write_n;
    assign back_wr = wr_en & ~address[3];
    assign ctrl_wr = wr_en & (address == ADDR_CTRL);

    assign row_done   = enable_q & (cnt_q == CNT_LAST);
    assign frame_wrap = row_done & (row_idx_q == 3'd7);
    // An idle engine has no frame boundary to wait for, so a pending swap lands at once.
    assign swap_apply = swap_pending_q & (frame_wrap | ~enable_q);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_done = 1'b1;
        end else begin : g_blank
            assign blank_done = (cnt_q >= CNT_W'(BLANK));
        end
    endgenerate

    assign visible = enable_q & blank_done;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        back_d = back_q;
        if (back_wr) begin
            back_d[address[2:0]] = writedata[7:0];
        end

        // The swap copies the pre-write back buffer, so a same-cycle back write is not seen.
        front_d = front_q;
        if (swap_apply) begin
            front_d = back_q;
        end

        enable_d = ctrl_wr ? writedata[0] : enable_q;
        invert_d = ctrl_wr ? writedata[1] : invert_q;

        // A new request beats the clear, so a request in the wrap cycle waits for the next wrap.
        swap_pending_d = (swap_pending_q & ~swap_apply) | (ctrl_wr & writedata[2]);

        cnt_d     = '0;
        row_idx_d = '0;
        if (enable_q && enable_d) begin
            if (row_done) begin
                row_idx_d = row_idx_q + 3'd1;
            end else begin
                cnt_d     = cnt_q + CNT_ONE;
                row_idx_d = row_idx_q;
            end
        end

        frame_count_d = frame_wrap ? (frame_count_q + 8'd1) : frame_count_q;
        frame_tick_d  = frame_wrap;

        row_sel_d  = visible ? (8'b1 << row_idx_q) : 8'h00;
        col_data_d = {8{invert_q}} ^ (visible ? front_q[row_idx_q] : 8'h00);
    end

    always_comb begin
        readdata = '0;
        if (!address[3]) begin
            readdata = {24'b0, back_q[address[2:0]]};
        end else if (address == ADDR_CTRL) begin
            readdata = {30'b0, invert_q, enable_q};
        end else if (address == ADDR_STATUS) begin
            readdata = {16'b0, frame_count_q, 3'b0, swap_pending_q, 1'b0, row_idx_q};
        end
    end

    // NOTE: the frame buffers are small flop arrays rather than RAM, so they clear with reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
            enable_q       <= 1'b0;
            invert_q       <= 1'b0;
            swap_pending_q <= 1'b0;
            row_idx_q      <= '0;
            cnt_q          <= '0;
            frame_count_q  <= '0;
            row_sel_q      <= '0;
            col_data_q     <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            back_q         <= back_d;
            front_q        <= front_d;
            enable_q       <= enable_d;
            invert_q       <= invert_d;
            swap_pending_q <= swap_pending_d;
            row_idx_q      <= row_idx_d;
            cnt_q          <= cnt_d;
            frame_count_q  <= frame_count_d;
            row_sel_q      <= row_sel_d;
            col_data_q     <= col_data_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_tick = frame_tick_q;

    assign unused_writedata = ^writedata[31:8];

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: directed scenarios plus randomized traffic
// compared every cycle against a scan-time based reference model.
module tb_led_matrix_scanner;

    localparam int P     = 4;
    localparam int B     = 1;
    localparam int FRAME = 8 * P;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    led_matrix_scanner #(.PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: scan position is a single time counter m_t within the frame.
    logic [7:0] m_back  [8];
    logic [7:0] m_front [8];
    logic       m_en, m_inv, m_pend;
    int         m_t;
    logic [7:0] m_frame;
    logic [7:0] e_row, e_col;
    logic       e_tick;
    bit         model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [2:0] r;
        r = 3'((m_t / P) % 8);
        if (a < 4'd8)  return {24'b0, m_back[a[2:0]]};
        if (a == 4'd8) return {30'b0, m_inv, m_en};
        if (a == 4'd9) return {16'b0, m_frame, 3'b0, m_pend, 1'b0, r};
        return 32'h0;
    endfunction

    task automatic model_step();
        logic wr, ctrl_wr, wrap, swap_now, new_en;
        int   row, cnt;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_back[i]  = 8'h00;
                m_front[i] = 8'h00;
            end
            m_en = 0; m_inv = 0; m_pend = 0; m_t = 0; m_frame = 0;
            e_row = 0; e_col = 0; e_tick = 0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        wr      = chipselect && !write_n;
        ctrl_wr = wr && (address == 4'd8);
        row     = (m_t / P) % 8;
        cnt     = m_t % P;
        if (m_en && cnt >= B) begin
            e_row = 8'(1 << row);
            e_col = m_front[row] ^ {8{m_inv}};
        end else begin
            e_row = 8'h00;
            e_col = {8{m_inv}};
        end
        wrap     = m_en && (m_t % FRAME == FRAME - 1);
        e_tick   = wrap;
        swap_now = m_pend && (wrap || !m_en);
        new_en   = ctrl_wr ? writedata[0] : m_en;
        if (wrap) m_frame = m_frame + 8'd1;
        if (swap_now) m_front = m_back;
        m_pend = (m_pend && !swap_now) || (ctrl_wr && writedata[2]);
        if (wr && address < 4'd8) m_back[address[2:0]] = writedata[7:0];
        if (ctrl_wr) m_inv = writedata[1];
        m_t  = (m_en && new_en) ? (m_t + 1) % FRAME : 0;
        m_en = new_en;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (model_valid) begin
            check("row_sel", {24'b0, row_sel}, {24'b0, e_row});
            check("col_data", {24'b0, col_data}, {24'b0, e_col});
            check("frame_tick", {31'b0, frame_tick}, {31'b0, e_tick});
            check("readdata", readdata, m_read(address));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_wrap_cycle();
        int n = 0;
        while (!(m_en && m_t == FRAME - 1) && n < 4 * FRAME) begin
            tick();
            n++;
        end
        check("wrap_cycle_found", {31'b0, (m_en && m_t == FRAME - 1)}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int ticks;
        bit found;

        reset = 1'b1; address = 4'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and readback
        check("rst_row_sel", {24'b0, row_sel}, 32'h0);
        check("rst_col_data", {24'b0, col_data}, 32'h0);
        for (int a = 0; a < 10; a++) begin
            rd(4'(a), d);
            check("rst_read", d, 32'h0);
        end
        wr(4'd3, 32'h1A5);
        rd(4'd3, d);
        check("back3_read", d, 32'h0000_00A5);

        // Scan timing: one-hot rows 0x01..0x80
        for (int i = 0; i < 8; i++) wr(4'(i), 32'(1 << i));
        wr(4'd8, 32'h4);
        wr(4'd8, 32'h1);
        for (int f = 0; f < 2; f++) begin
            ticks = 0;
            for (int k = 0; k < FRAME; k++) begin
                tick();
                check("seq_row_sel", {24'b0, row_sel}, (k % P < B) ? 32'h0 : 32'(1 << (k / P)));
                check("seq_col_data", {24'b0, col_data}, (k % P < B) ? 32'h0 : 32'(1 << (k / P)));
                ticks += int'(frame_tick);
            end
            check("ticks_per_frame", 32'(ticks), 32'd1);
            rd(4'd9, d);
            check("status_frame", {24'b0, d[15:8]}, 32'(f + 1));
            check("status_row", {29'b0, d[2:0]}, 32'h0);
        end

        // Double buffering
        wr(4'd0, 32'hFF);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (row_sel == 8'h01) check("no_swap_row0", {24'b0, col_data}, 32'h01);
        end
        wr(4'd8, 32'h5);
        rd(4'd9, d);
        check("pend_set", {31'b0, d[4]}, 32'd1);
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            tick();
            if (frame_tick) found = 1;
            else begin
                rd(4'd9, d);
                check("pend_hold", {31'b0, d[4]}, 32'd1);
            end
        end
        check("swap_wrap_found", {31'b0, found}, 32'd1);
        found = 0;
        for (int k = 0; k < FRAME && !found; k++) begin
            tick();
            if (row_sel == 8'h01) begin
                found = 1;
                check("swapped_row0", {24'b0, col_data}, 32'hFF);
                rd(4'd9, d);
                check("pend_clear", {31'b0, d[4]}, 32'd0);
            end
        end
        check("row0_found", {31'b0, found}, 32'd1);

        // Invert with front[2]=0x0F
        wr(4'd8, 32'h0);
        wr(4'd2, 32'h0F);
        wr(4'd8, 32'h4);
        wr(4'd8, 32'h3);
        for (int k = 0; k < FRAME + 8; k++) begin
            tick();
            if (row_sel == 8'h00) check("inv_blank", {24'b0, col_data}, 32'hFF);
            if (row_sel == 8'h04) check("inv_row2", {24'b0, col_data}, 32'hF0);
        end

        // Disable mid-scan at row 5
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            rd(4'd9, d);
            if (d[2:0] == 3'd5) found = 1;
            else tick();
        end
        check("row5_found", {31'b0, found}, 32'd1);
        wr(4'd8, 32'h0);
        rd(4'd9, d);
        check("dis_row_idx", {29'b0, d[2:0]}, 32'h0);
        tick();
        check("dis_row_sel", {24'b0, row_sel}, 32'h0);
        check("dis_col_data", {24'b0, col_data}, 32'h0);
        wr(4'd8, 32'h1);
        rd(4'd9, d);
        check("reen_row_idx", {29'b0, d[2:0]}, 32'h0);
        tick();
        check("reen_blank", {24'b0, row_sel}, 32'h0);
        tick();
        check("reen_row0", {24'b0, row_sel}, 32'h01);

        // Back write in the wrap cycle with a swap pending
        wr(4'd0, 32'hAA);
        wr(4'd8, 32'h5);
        wait_wrap_cycle();
        wr(4'd0, 32'h55);
        rd(4'd0, d);
        check("coll_back0", d, 32'h55);
        rd(4'd9, d);
        check("coll_pend", {31'b0, d[4]}, 32'd0);
        found = 0;
        for (int k = 0; k < FRAME && !found; k++) begin
            tick();
            if (row_sel == 8'h01) begin
                found = 1;
                check("coll_front0", {24'b0, col_data}, 32'hAA);
            end
        end
        check("coll_row0_found", {31'b0, found}, 32'd1);

        // Swap request in the wrap cycle waits for the following wrap
        wait_wrap_cycle();
        wr(4'd8, 32'h5);
        rd(4'd9, d);
        check("req_at_wrap_pend", {31'b0, d[4]}, 32'd1);
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            tick();
            if (frame_tick) found = 1;
        end
        rd(4'd9, d);
        check("req_at_wrap_done", {31'b0, d[4]}, 32'd0);

        // Reset mid-frame
        wr(4'd8, 32'h3);
        for (int k = 0; k < 13; k++) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_row_sel", {24'b0, row_sel}, 32'h0);
        check("mid_rst_col_data", {24'b0, col_data}, 32'h0);
        check("mid_rst_tick", {31'b0, frame_tick}, 32'h0);
        rd(4'd9, d);
        check("mid_rst_status", d, 32'h0);
        rd(4'd8, d);
        check("mid_rst_ctrl", d, 32'h0);
        reset = 1'b0;

        // Randomized traffic, checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = $urandom_range(0, 1) == 1;
            address    = ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            writedata  = $urandom;
            if (address == 4'd8) writedata[0] = ($urandom_range(0, 4) != 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
